// File: rtl/led_sequencer.sv
// Drives the 8-LED bank with off/static/scanner/blink patterns, advanced at a programmable step rate.
// Config writes take effect on the cycle after acceptance; led/step_pulse are registered.
// cfg_ready drops for the one cycle after each accepted write, so writes are at most one per 2 cycles.
module led_sequencer #(
   parameter int unsigned CLOCK_RATE = 100000000,
   parameter int unsigned TICK_DIV   = CLOCK_RATE / 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic [7:0] led,
   output logic       step_pulse
);

   localparam int unsigned       PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]     PRE_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] ADDR_MODE  = 2'd0;
   localparam logic [1:0] ADDR_PAT   = 2'd1;
   localparam logic [1:0] ADDR_SPEED = 2'd2;
   localparam logic [1:0] ADDR_CTRL  = 2'd3;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STATIC = 2'd1;
   localparam logic [1:0] MODE_SCAN   = 2'd2;

   typedef enum logic [2:0] {
      S_OFF,
      S_STATIC,
      S_SCAN_L,
      S_SCAN_R,
      S_BLINK_ON,
      S_BLINK_OFF
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    led_q, led_d;
   logic          step_pulse_q, step_pulse_d;
   logic          cfg_ready_q;
   logic [1:0]    mode_q;
   logic [7:0]    pattern_q;
   logic [7:0]    speed_q;
   logic          run_q;
   logic [PW-1:0] presc_q;
   logic [7:0]    stepcnt_q;

   logic          accept;
   logic          restart;
   logic          tick;
   logic          step_due;
   logic          step;
   logic [7:0]    speed_eff;
   logic [1:0]    entry_mode;

   assign accept     = cfg_valid && cfg_ready_q;
   // A MODE write (even of the same value) and a CTRL restart both re-enter the mode from scratch.
   assign restart    = accept && ((cfg_addr == ADDR_MODE) || ((cfg_addr == ADDR_CTRL) && cfg_data[1]));
   assign entry_mode = (cfg_addr == ADDR_MODE) ? cfg_data[1:0] : mode_q;
   assign speed_eff  = (speed_q == 8'd0) ? 8'd1 : speed_q;
   assign tick       = run_q && (presc_q == PRE_MAX);
   assign step_due   = stepcnt_q >= (speed_eff - 8'd1);
   // Register values seen here are pre-write, so a same-cycle PATTERN/SPEED/run write never alters this step.
   assign step       = tick && step_due && !restart;

   assign cfg_ready  = cfg_ready_q;
   assign led        = led_q;
   assign step_pulse = step_pulse_q;

   // Handshake: ready drops for exactly the cycle after an accept.
   always_ff @(posedge clk) begin
      if (rst) cfg_ready_q <= 1'b1;
      else     cfg_ready_q <= !accept;
   end

   // Configuration register file; the restart bit is an action, not state.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= MODE_SCAN;
         pattern_q <= 8'hFF;
         speed_q   <= 8'd1;
         run_q     <= 1'b1;
      end else if (accept) begin
         case (cfg_addr)
            ADDR_MODE:  mode_q    <= cfg_data[1:0];
            ADDR_PAT:   pattern_q <= cfg_data;
            ADDR_SPEED: speed_q   <= cfg_data;
            default:    run_q     <= cfg_data[0];
         endcase
      end
   end

   // Prescaler and step counter; frozen while paused, cleared on mode (re)entry.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         presc_q   <= '0;
         stepcnt_q <= 8'd0;
      end else if (run_q) begin
         presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + PW'(1);
         if (tick) stepcnt_q <= step_due ? 8'd0 : stepcnt_q + 8'd1;
      end
   end

   // Pattern state, LED and step pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_SCAN_L;
         led_q        <= 8'h01;
         step_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         led_q        <= led_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   // Next state: mode entry wins over a coincident step; OFF/STATIC never pulse.
   always_comb begin
      state_d      = state_q;
      led_d        = led_q;
      step_pulse_d = 1'b0;
      if (restart) begin
         case (entry_mode)
            MODE_OFF: begin
               state_d = S_OFF;
               led_d   = 8'h00;
            end
            MODE_STATIC: begin
               state_d = S_STATIC;
               led_d   = pattern_q;
            end
            MODE_SCAN: begin
               state_d = S_SCAN_L;
               led_d   = 8'h01;
            end
            default: begin
               state_d = S_BLINK_ON;
               led_d   = pattern_q;
            end
         endcase
      end else begin
         case (state_q)
            S_OFF: led_d = 8'h00;
            S_STATIC: begin
               if (accept && (cfg_addr == ADDR_PAT)) led_d = cfg_data;
            end
            S_SCAN_L: begin
               if (step) begin
                  step_pulse_d = 1'b1;
                  if (led_q == 8'h80) begin
                     state_d = S_SCAN_R;
                     led_d   = 8'h40;
                  end else begin
                     led_d = led_q << 1;
                  end
               end
            end
            S_SCAN_R: begin
               if (step) begin
                  step_pulse_d = 1'b1;
                  if (led_q == 8'h01) begin
                     state_d = S_SCAN_L;
                     led_d   = 8'h02;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            S_BLINK_ON: begin
               if (step) begin
                  step_pulse_d = 1'b1;
                  state_d      = S_BLINK_OFF;
                  led_d        = 8'h00;
               end
            end
            S_BLINK_OFF: begin
               if (step) begin
                  step_pulse_d = 1'b1;
                  state_d      = S_BLINK_ON;
                  led_d        = pattern_q;
               end
            end
            default: begin
               state_d = S_SCAN_L;
               led_d   = 8'h01;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer with a behavioural reference model.
// Model tracks scan position / blink phase and tick counts as plain integers.
// Outputs compared every cycle on the falling edge.
module tb_led_sequencer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] led;
   logic       step_pulse;

   int checks = 0;
   int errors = 0;

   // model state
   int m_mode, m_pat, m_speed, m_run, m_rdy;
   int ph, tk, kind, pos, bon, shown, pulse;

   led_sequencer #(.CLOCK_RATE(96), .TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .led        (led),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] model_led();
      int p;
      case (kind)
         0: return 8'h00;
         1: return shown[7:0];
         2: begin
            p = (pos <= 7) ? pos : 14 - pos;
            return 8'(1 << p);
         end
         default: return bon ? shown[7:0] : 8'h00;
      endcase
   endfunction

   task automatic model_update();
      int acc, rs, is_tick, sp, do_step;
      if (rst) begin
         m_mode = 2; m_pat = 8'hFF; m_speed = 1; m_run = 1; m_rdy = 1;
         ph = 0; tk = 0; kind = 2; pos = 0; bon = 1; shown = 8'hFF; pulse = 0;
         return;
      end
      acc     = (cfg_valid && m_rdy) ? 1 : 0;
      rs      = (acc && (cfg_addr == 2'd0 || (cfg_addr == 2'd3 && cfg_data[1]))) ? 1 : 0;
      is_tick = (m_run && ph == TD - 1) ? 1 : 0;
      sp      = (m_speed == 0) ? 1 : m_speed;
      do_step = (is_tick && tk + 1 >= sp && !rs) ? 1 : 0;
      pulse   = 0;
      if (rs) begin
         kind  = (cfg_addr == 2'd0) ? int'(cfg_data[1:0]) : m_mode;
         pos   = 0;
         bon   = 1;
         shown = m_pat;
         ph    = 0;
         tk    = 0;
      end else begin
         if (m_run) begin
            if (is_tick) tk = (tk + 1 >= sp) ? 0 : tk + 1;
            ph = (ph + 1) % TD;
         end
         if (do_step && kind == 2) begin
            pulse = 1;
            pos = (pos + 1) % 14;
         end else if (do_step && kind == 3) begin
            pulse = 1;
            bon = 1 - bon;
            if (bon) shown = m_pat;
         end
         if (acc && cfg_addr == 2'd1 && kind == 1) shown = cfg_data;
      end
      if (acc) begin
         case (cfg_addr)
            2'd0: m_mode = cfg_data[1:0];
            2'd1: m_pat = cfg_data;
            2'd2: m_speed = cfg_data;
            default: m_run = cfg_data[0];
         endcase
      end
      m_rdy = acc ? 0 : 1;
   endtask

   // one clock: model follows the edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("led", led, model_led());
      chk("step_pulse", {7'd0, step_pulse}, pulse[7:0]);
      chk("cfg_ready", {7'd0, cfg_ready}, m_rdy[7:0]);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      cycle();
      cfg_valid = 1'b0;
      cycle();
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
      @(negedge clk);
      repeat (3) cycle();
      chk("reset_led", led, 8'h01);
      rst = 1'b0;
      repeat (70) cycle();
      // static then pattern
      wr(2'd0, 8'd1);
      wr(2'd1, 8'hA5);
      repeat (10) cycle();
      chk("static_led", led, 8'hA5);
      // blink with slow speed, then speed 0
      wr(2'd1, 8'h3C);
      wr(2'd2, 8'd3);
      wr(2'd0, 8'd3);
      repeat (60) cycle();
      wr(2'd2, 8'd0);
      repeat (20) cycle();
      // scan, pause, resume
      wr(2'd0, 8'd2);
      repeat (9) cycle();
      wr(2'd3, 8'd0);
      repeat (50) cycle();
      wr(2'd3, 8'd1);
      repeat (30) cycle();
      // reset mid-blink
      wr(2'd0, 8'd3);
      repeat (6) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_led", led, 8'h01);
      repeat (20) cycle();
      // randomized traffic
      for (int i = 0; i < 8000; i++) begin
         cfg_valid = ($urandom_range(0, 99) < 15);
         cfg_addr  = 2'($urandom_range(0, 3));
         cfg_data  = 8'($urandom);
         if (cfg_addr == 2'd2) cfg_data = 8'($urandom_range(0, 3));
         if (cfg_addr == 2'd3) cfg_data = {6'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
         rst = ($urandom_range(0, 699) == 0);
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Run-time controller for the 8-LED bank on the board. It owns the `led` outputs and produces one of four patterns: off, static, bouncing scanner, or blink. Patterns advance at a programmable step rate derived from the system clock. A small valid/ready register-write port lets an upstream command decoder (e.g. the USB-UART path) reconfigure it while running. Out of reset it produces the familiar bouncing scanner with no configuration needed.

## Interface
- `CLOCK_RATE`, 100000000, system clock frequency in Hz (informational; used only to derive the default of `TICK_DIV`).
- `TICK_DIV`, CLOCK_RATE/24, clock cycles per base tick; minimum 2. Prescaler width is $clog2(TICK_DIV).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  write request.
- `cfg_ready`  out  1  write can be accepted this cycle.
- `cfg_addr`  in  2  register select: 0 MODE, 1 PATTERN, 2 SPEED, 3 CTRL.
- `cfg_data`  in  8  write data.
- `led`  out  8  LED drive, 1 = lit.
- `step_pulse`  out  1  high for exactly one cycle whenever the pattern advances.

## Operation
**Registers** (reset value in brackets):
- MODE[1:0] [2]: 0 OFF, 1 STATIC, 2 SCAN, 3 BLINK. Bits 7:2 are ignored.
- PATTERN [0xFF]: the static pattern and the blink on-pattern.
- SPEED [1]: base ticks per step. Value 0 is treated as 1.
- CTRL [run=1]: bit0 = run. bit1 = restart, which is self-clearing and not stored.

**Write handshake:**
- A write is accepted when `cfg_valid && cfg_ready`.
- `cfg_ready` is low for the one cycle following each accepted write, then high again.
- Back-to-back writes therefore take 2 cycles each.

**Prescaler and step counter:**
- The prescaler counts 0..TICK_DIV-1 and wraps. The tick is the cycle in which the count is TICK_DIV-1.
- The step counter counts ticks 0..SPEED_eff-1. A step occurs on the tick where the counter is >= SPEED_eff-1; the counter then returns to 0.
- When run=0, both counters and `led` are frozen and no steps occur.

**States:** OFF, STATIC, SCAN_L, SCAN_R, BLINK_ON, BLINK_OFF.
- OFF: `led`=0. Steps are ignored.
- STATIC: `led`=PATTERN. A PATTERN write updates `led` on the cycle after acceptance. Steps are ignored.
- SCAN_L: each step shifts `led` left. When `led` is 0x80, the step moves to SCAN_R with `led`=0x40.
- SCAN_R: each step shifts `led` right. When `led` is 0x01, the step moves to SCAN_L with `led`=0x02.
- The scan sequence is 01,02,…,80,40,…,01,02…, a period of 14 steps, with each end shown once.
- BLINK_ON (`led`=PATTERN) and BLINK_OFF (`led`=0) alternate on every step. A PATTERN write takes effect at the next BLINK_ON.

**Mode entry:**
- A MODE write or a restart clears the prescaler and step counter.
- It then enters the mode's initial state on the cycle after acceptance:
  - OFF → OFF.
  - STATIC → STATIC.
  - SCAN → SCAN_L with `led`=0x01.
  - BLINK → BLINK_ON.
- Rewriting the current MODE value also restarts it.

**SPEED write:** does not clear the step counter. If the counter is already >= the new SPEED_eff-1, the step happens on the next tick.

**Simultaneous events:**
- A MODE write or restart accepted on a tick cycle suppresses that step: no `led` change and no `step_pulse`.
- A PATTERN, SPEED or run write on a tick cycle does not suppress the step. The step uses the pre-write register values.

**Reset:**
- Mid-operation reset returns all registers to reset values, enters SCAN_L with `led`=0x01, and clears both counters.
- `step_pulse` resets to 0 and `cfg_ready` resets to 1.

## Timing
- All outputs are registered.
- `led` and `step_pulse` change on the same edge. `step_pulse` is high during the first cycle showing the new value.
- After reset release with SPEED=1, the first step is visible TICK_DIV cycles later. Steps then repeat every TICK_DIV·SPEED_eff cycles.
- Config latency: write accepted at edge N, effect visible after edge N+1.
- `cfg_ready` is low in cycle N+1 and high again in cycle N+2.

## Test plan
- **Reset scan:** TICK_DIV=4, hold `rst` 3 cycles, release. Required: `led` = 01,02,…,80,40,…,01,02, each change every 4 cycles with a 1-cycle `step_pulse`, and a 14-step period.
- **Static/pattern:** write MODE=1, then PATTERN=0xA5. Required: `led`=0xFF the cycle after the MODE accept, then 0xA5 the cycle after the PATTERN accept; `step_pulse` stays 0; `cfg_ready` is low exactly 1 cycle after each accept.
- **Blink with SPEED:** TICK_DIV=4, PATTERN=0x3C, SPEED=3, MODE=3. Required: `led` alternates 0x3C/0x00 every 12 cycles. Then write SPEED=0; required: the period becomes 4 cycles.
- **Pause:** run=0 mid-scan at `led`=0x08 for 50 cycles. Required: `led` is held at 0x08 with no pulses. Then run=1; required: the next step is 0x10 after the remaining prescaler and step counts.
- **Collision:** MODE=2 write accepted on a tick cycle while `led`=0x20. Required: no step on that edge, `led`=0x01 the next cycle, and the next step 4 cycles later.
- **Reset mid-blink:** assert `rst` during BLINK_OFF. Required: the next cycle shows `led`=0x01, `cfg_ready`=1 and `step_pulse`=0, and the scan resumes.
